// File: rtl/rggen_axi4lite_responder.sv
// AXI4-Lite subordinate front end for a rggen register block.
// Buffers one AW, one W and one AR request, then turns each into a single
// rggen bus access and returns the rggen status and read data on B or R.
module rggen_axi4lite_responder #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  localparam int IDW          = (ID_WIDTH == 0) ? 1 : ID_WIDTH,
  localparam int STRB_WIDTH   = BUS_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [IDW-1:0]           i_awid,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic [2:0]               i_awprot,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [STRB_WIDTH-1:0]    i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [IDW-1:0]           o_bid,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [IDW-1:0]           i_arid,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  input  logic [2:0]               i_arprot,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [IDW-1:0]           o_rid,
  output logic [1:0]               o_rresp,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [STRB_WIDTH-1:0]    o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic                     sel_write_reg, sel_write_next;
  logic                     last_write_reg;
  logic                     aw_held_reg, w_held_reg, ar_held_reg;
  logic [IDW-1:0]           aw_id_reg, ar_id_reg;
  logic [ADDRESS_WIDTH-1:0] aw_addr_reg, ar_addr_reg;
  logic [BUS_WIDTH-1:0]     w_data_reg;
  logic [STRB_WIDTH-1:0]    w_strb_reg;
  logic                     bus_done;
  logic                     unused_prot;

  // Protection attributes carry no meaning for the register map.
  assign unused_prot = ^{i_awprot, i_arprot};

  // Each channel accepts whenever its one-entry holding register is empty.
  assign o_awready = !aw_held_reg;
  assign o_wready  = !w_held_reg;
  assign o_arready = !ar_held_reg;

  assign bus_done  = (state_reg == BUS) && i_bus_ready;
  assign o_bvalid  = (state_reg == RESP) && sel_write_reg;
  assign o_rvalid  = (state_reg == RESP) && !sel_write_reg;

  // AW holding register: filled on handshake, emptied when its write completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      aw_held_reg <= 1'b0;
      aw_id_reg   <= '0;
      aw_addr_reg <= '0;
    end else if (i_awvalid && !aw_held_reg) begin
      aw_held_reg <= 1'b1;
      aw_id_reg   <= i_awid;
      aw_addr_reg <= i_awaddr;
    end else if (bus_done && sel_write_reg) begin
      aw_held_reg <= 1'b0;
    end
  end

  // W holding register: filled on handshake, emptied when its write completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_held_reg <= 1'b0;
      w_data_reg <= '0;
      w_strb_reg <= '0;
    end else if (i_wvalid && !w_held_reg) begin
      w_held_reg <= 1'b1;
      w_data_reg <= i_wdata;
      w_strb_reg <= i_wstrb;
    end else if (bus_done && sel_write_reg) begin
      w_held_reg <= 1'b0;
    end
  end

  // AR holding register: filled on handshake, emptied when its read completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ar_held_reg <= 1'b0;
      ar_id_reg   <= '0;
      ar_addr_reg <= '0;
    end else if (i_arvalid && !ar_held_reg) begin
      ar_held_reg <= 1'b1;
      ar_id_reg   <= i_arid;
      ar_addr_reg <= i_araddr;
    end else if (bus_done && !sel_write_reg) begin
      ar_held_reg <= 1'b0;
    end
  end

  // FSM state, selected direction and round-robin history (starts as "read").
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      sel_write_reg  <= 1'b0;
      last_write_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_write_reg <= sel_write_next;
      if (bus_done) begin
        last_write_reg <= sel_write_reg;
      end
    end
  end

  // Next state: pick an eligible direction in IDLE, alternating under contention.
  always_comb begin
    state_next     = state_reg;
    sel_write_next = sel_write_reg;
    case (state_reg)
      IDLE: begin
        if ((aw_held_reg && w_held_reg) && (!ar_held_reg || !last_write_reg)) begin
          sel_write_next = 1'b1;
          state_next     = BUS;
        end else if (ar_held_reg) begin
          sel_write_next = 1'b0;
          state_next     = BUS;
        end
      end
      BUS: begin
        if (i_bus_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (sel_write_reg ? i_bready : i_rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // rggen request fields come straight from the selected holding register.
  always_comb begin
    o_bus_valid      = 1'b0;
    o_bus_access     = 2'b00;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (state_reg == BUS) begin
      o_bus_valid = 1'b1;
      if (sel_write_reg) begin
        o_bus_access     = 2'b01;
        o_bus_address    = aw_addr_reg;
        o_bus_write_data = w_data_reg;
        o_bus_strobe     = w_strb_reg;
      end else begin
        o_bus_access  = 2'b10;
        o_bus_address = ar_addr_reg;
        o_bus_strobe  = '1;
      end
    end
  end

  // Response registers: loaded when the rggen access completes, held through RESP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bid   <= '0;
      o_bresp <= 2'b00;
      o_rid   <= '0;
      o_rresp <= 2'b00;
      o_rdata <= '0;
    end else if (bus_done) begin
      if (sel_write_reg) begin
        o_bid   <= aw_id_reg;
        o_bresp <= i_bus_status;
      end else begin
        o_rid   <= ar_id_reg;
        o_rresp <= i_bus_status;
        o_rdata <= i_bus_read_data;
      end
    end
  end

endmodule
